// File: rtl/cl_fsb_pkg.sv
// Shared FSB definitions for the cl_fsb node array and its link arbiter.
package cl_fsb_pkg;

  localparam int unsigned fsb_width_gp    = 80;
  localparam int unsigned fsb_id_lsb_gp   = 76;
  localparam int unsigned fsb_id_width_gp = 4;

  // Destination ID sits in the top nibble; the rest is opaque payload.
  typedef struct packed {
    logic [fsb_id_width_gp-1:0]              id;
    logic [fsb_width_gp-fsb_id_width_gp-1:0] payload;
  } fsb_pkt_s;

endpackage

// File: rtl/fsb_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i, wrapping at NumReq.
module fsb_rr_pick
  import cl_fsb_pkg::*;
#(
  parameter int unsigned NumReq = 10
) (
  input  logic [NumReq-1:0]          req_i,
  input  logic [fsb_id_width_gp-1:0] ptr_i,
  output logic                       grant_v_o,
  output logic [fsb_id_width_gp-1:0] grant_idx_o,
  output logic [NumReq-1:0]          grant_o
);

  logic [15:0] req_ext;
  logic [15:0] grant_ext;
  logic [4:0]  cand;

  assign req_ext = 16'(req_i);
  assign grant_o = grant_ext[NumReq-1:0];

  // Walk the ring starting at the pointer; the first valid request wins.
  always_comb begin
    grant_v_o   = 1'b0;
    grant_idx_o = '0;
    grant_ext   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 5'(ptr_i) + 5'(k);
      // ptr_i < NumReq, so a single subtraction wraps modulo NumReq.
      if (cand >= 5'(NumReq)) begin
        cand = cand - 5'(NumReq);
      end
      if (!grant_v_o && req_ext[cand[3:0]]) begin
        grant_v_o   = 1'b1;
        grant_idx_o = cand[3:0];
        grant_ext   = 16'b1 << cand[3:0];
      end
    end
  end

endmodule

// File: rtl/fsb_rr_arbiter.sv
// Round-robin share of one FSB link among num_nodes_p nodes: registered outbound merge,
// combinational inbound demux by destination ID, and a saturating drop counter.
module fsb_rr_arbiter
  import cl_fsb_pkg::*;
#(
  parameter int unsigned num_nodes_p = 10,
  parameter int unsigned width_p     = fsb_width_gp,
  parameter int unsigned id_lsb_p    = fsb_id_lsb_gp
) (
  input  logic                           clk,
  input  logic                           pipe_rst_n,
  // Outbound: nodes -> link
  input  logic [num_nodes_p-1:0]         node_v_i,
  input  logic [num_nodes_p*width_p-1:0] node_data_i,
  output logic [num_nodes_p-1:0]         node_yumi_o,
  output logic                           link_v_o,
  output logic [width_p-1:0]             link_data_o,
  input  logic                           link_ready_i,
  // Inbound: link -> nodes
  input  logic                           link_v_i,
  input  logic [width_p-1:0]             link_data_i,
  output logic                           link_yumi_o,
  output logic [num_nodes_p-1:0]         node_v_o,
  output logic [num_nodes_p*width_p-1:0] node_data_o,
  input  logic [num_nodes_p-1:0]         node_ready_i,
  // Status
  output logic [15:0]                    drop_count_o,
  output logic [3:0]                     last_grant_o
);

  localparam int unsigned IdW = fsb_id_width_gp;

  // ---------------------------------------------------------------------------
  // Outbound path
  // ---------------------------------------------------------------------------
  logic                   link_v_q, link_v_d;
  logic [width_p-1:0]     link_data_q, link_data_d;
  logic [IdW-1:0]         rr_q, rr_d;
  logic [3:0]             last_grant_q, last_grant_d;

  logic                   load;
  logic                   grant_v;
  logic [IdW-1:0]         grant_idx;
  logic [num_nodes_p-1:0] grant;

  assign load = ~link_v_q | link_ready_i;

  fsb_rr_pick #(
    .NumReq (num_nodes_p)
  ) u_pick (
    .req_i       (node_v_i),
    .ptr_i       (rr_q),
    .grant_v_o   (grant_v),
    .grant_idx_o (grant_idx),
    .grant_o     (grant)
  );

  // Yumi is held low during reset so no packet is consumed that the register cannot keep.
  assign node_yumi_o = (load && grant_v && pipe_rst_n) ? grant : '0;

  // Next state of the output register, pointer and last-grant index.
  always_comb begin
    link_v_d     = link_v_q;
    link_data_d  = link_data_q;
    rr_d         = rr_q;
    last_grant_d = last_grant_q;
    if (load) begin
      if (grant_v) begin
        link_v_d     = 1'b1;
        last_grant_d = 4'(grant_idx);
        rr_d         = (grant_idx == IdW'(num_nodes_p - 1)) ? '0 : grant_idx + 1'b1;
        for (int unsigned i = 0; i < num_nodes_p; i++) begin
          if (grant[i]) begin
            link_data_d = node_data_i[width_p*i +: width_p];
          end
        end
      end else begin
        link_v_d = 1'b0;
      end
    end
  end

  // Outbound state registers.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      link_v_q     <= 1'b0;
      link_data_q  <= '0;
      rr_q         <= '0;
      last_grant_q <= '0;
    end else begin
      link_v_q     <= link_v_d;
      link_data_q  <= link_data_d;
      rr_q         <= rr_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign link_v_o     = link_v_q;
  assign link_data_o  = link_data_q;
  assign last_grant_o = last_grant_q;

  // ---------------------------------------------------------------------------
  // Inbound path
  // ---------------------------------------------------------------------------
  logic [IdW-1:0] dest;
  logic           dest_in_range;
  logic [15:0]    node_ready_ext;
  logic           drop;
  logic [15:0]    drop_count_q, drop_count_d;

  assign dest           = link_data_i[id_lsb_p +: IdW];
  assign dest_in_range  = (5'(dest) < 5'(num_nodes_p));
  assign node_ready_ext = 16'(node_ready_i);
  assign node_data_o    = {num_nodes_p{link_data_i}};

  // Demux valid to the addressed node; out-of-range IDs are swallowed.
  always_comb begin
    node_v_o = '0;
    for (int unsigned i = 0; i < num_nodes_p; i++) begin
      node_v_o[i] = link_v_i && (dest == IdW'(i));
    end
    link_yumi_o = link_v_i && (dest_in_range ? node_ready_ext[dest] : 1'b1);
    drop        = link_v_i && !dest_in_range;
  end

  // Saturating drop count.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count_o = drop_count_q;

  // Only the destination nibble of inbound packets steers logic here.
  logic unused_link_data;
  assign unused_link_data = ^link_data_i;

endmodule

// File: tb/tb_fsb_rr_arbiter.sv
// Directed self-checking bench for fsb_rr_arbiter (N=10, 80-bit packets).
module tb_fsb_rr_arbiter;
  import cl_fsb_pkg::*;

  localparam int unsigned N = 10;
  localparam int unsigned W = 80;

  logic             clk;
  logic             pipe_rst_n;
  logic [N-1:0]     node_v_i;
  logic [N*W-1:0]   node_data_i;
  logic [N-1:0]     node_yumi_o;
  logic             link_v_o;
  logic [W-1:0]     link_data_o;
  logic             link_ready_i;
  logic             link_v_i;
  logic [W-1:0]     link_data_i;
  logic             link_yumi_o;
  logic [N-1:0]     node_v_o;
  logic [N*W-1:0]   node_data_o;
  logic [N-1:0]     node_ready_i;
  logic [15:0]      drop_count_o;
  logic [3:0]       last_grant_o;

  int n_checks = 0;
  int n_fails  = 0;

  fsb_rr_arbiter #(
    .num_nodes_p (N),
    .width_p     (W),
    .id_lsb_p    (76)
  ) dut (
    .clk          (clk),
    .pipe_rst_n   (pipe_rst_n),
    .node_v_i     (node_v_i),
    .node_data_i  (node_data_i),
    .node_yumi_o  (node_yumi_o),
    .link_v_o     (link_v_o),
    .link_data_o  (link_data_o),
    .link_ready_i (link_ready_i),
    .link_v_i     (link_v_i),
    .link_data_i  (link_data_i),
    .link_yumi_o  (link_yumi_o),
    .node_v_o     (node_v_o),
    .node_data_o  (node_data_o),
    .node_ready_i (node_ready_i),
    .drop_count_o (drop_count_o),
    .last_grant_o (last_grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] node_pkt(input int i);
    return 80'h0000_CAFE_0000_0000_0000 + 80'(i);
  endfunction

  function automatic logic [W-1:0] in_pkt(input logic [3:0] id);
    fsb_pkt_s p;
    p.id      = id;
    p.payload = 76'h5_1234_5678_9ABC_DEF0;
    return p;
  endfunction

  // Land 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    node_v_i     = '0;
    link_ready_i = 1'b0;
    link_v_i     = 1'b0;
    pipe_rst_n   = 1'b0;
    step();
    pipe_rst_n   = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) node_data_i[W*i +: W] = node_pkt(i);
    link_data_i  = '0;
    node_ready_i = '0;
    node_v_i     = '0;
    link_ready_i = 1'b0;
    link_v_i     = 1'b0;
    pipe_rst_n   = 1'b0;

    // Reset state, yumi forced low even with requests present.
    node_v_i = 10'h3FF;
    step();
    #1;
    check("rst_link_v", W'(link_v_o), 80'd0);
    check("rst_link_data", link_data_o, 80'd0);
    check("rst_last_grant", W'(last_grant_o), 80'd0);
    check("rst_drop_count", W'(drop_count_o), 80'd0);
    check("rst_yumi", W'(node_yumi_o), 80'd0);

    // Single request from node 2.
    pipe_rst_n   = 1'b1;
    node_v_i     = 10'h004;
    link_ready_i = 1'b1;
    #1;
    check("single_yumi", W'(node_yumi_o), 80'h004);
    step();
    check("single_link_v", W'(link_v_o), 80'd1);
    check("single_link_data", link_data_o, node_pkt(2));
    check("single_last_grant", W'(last_grant_o), 80'd2);
    node_v_i = 10'h3FF;
    #1;
    check("single_rr_is_3", W'(node_yumi_o), 80'h008);

    // All-valid rotation from a fresh pointer: 0..9,0,1 with no bubbles.
    do_reset();
    node_v_i     = 10'h3FF;
    link_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("rot_yumi_%0d", k), W'(node_yumi_o), W'(10'b1 << (k % 10)));
      step();
      check($sformatf("rot_last_%0d", k), W'(last_grant_o), W'(k % 10));
      check($sformatf("rot_data_%0d", k), link_data_o, node_pkt(k % 10));
      check($sformatf("rot_v_%0d", k), W'(link_v_o), 80'd1);
    end

    // Backpressure: first grant fills the empty register, then nothing moves.
    do_reset();
    node_v_i     = 10'h3FF;
    link_ready_i = 1'b0;
    #1;
    check("bp_first_yumi", W'(node_yumi_o), 80'h001);
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_yumi_%0d", k), W'(node_yumi_o), 80'd0);
      check($sformatf("bp_data_%0d", k), link_data_o, node_pkt(0));
      check($sformatf("bp_v_%0d", k), W'(link_v_o), 80'd1);
      step();
    end
    link_ready_i = 1'b1;
    #1;
    check("bp_release_yumi", W'(node_yumi_o), 80'h002);
    step();
    check("bp_release_data", link_data_o, node_pkt(1));
    check("bp_release_last", W'(last_grant_o), 80'd1);

    // Reset while the register holds an unaccepted packet.
    link_ready_i = 1'b0;
    #1;
    check("mid_held_v", W'(link_v_o), 80'd1);
    #2;
    pipe_rst_n = 1'b0;
    #1;
    check("mid_rst_v", W'(link_v_o), 80'd0);
    check("mid_rst_data", link_data_o, 80'd0);
    check("mid_rst_yumi", W'(node_yumi_o), 80'd0);
    #1;
    pipe_rst_n   = 1'b1;
    link_ready_i = 1'b1;
    #1;
    check("mid_after_yumi", W'(node_yumi_o), 80'h001);
    step();
    check("mid_after_last", W'(last_grant_o), 80'd0);
    check("mid_after_data", link_data_o, node_pkt(0));

    // Inbound routing.
    do_reset();
    link_v_i     = 1'b1;
    link_data_i  = in_pkt(4'd7);
    node_ready_i = '0;
    #1;
    check("in7_node_v", W'(node_v_o), 80'h080);
    check("in7_yumi_blocked", W'(link_yumi_o), 80'd0);
    check("in7_bcast", node_data_o[W*7 +: W], in_pkt(4'd7));
    node_ready_i = 10'h080;
    #1;
    check("in7_yumi_ready", W'(link_yumi_o), 80'd1);
    link_data_i = in_pkt(4'd3);
    #1;
    check("in3_node_v", W'(node_v_o), 80'h008);
    check("in3_yumi_wrong_ready", W'(link_yumi_o), 80'd0);
    link_data_i = in_pkt(4'd9);
    node_ready_i = 10'h200;
    #1;
    check("in9_yumi", W'(link_yumi_o), 80'd1);
    step();
    check("in_no_drop", W'(drop_count_o), 80'd0);
    link_v_i = 1'b0;
    #1;
    check("in_idle_yumi", W'(link_yumi_o), 80'd0);
    check("in_idle_node_v", W'(node_v_o), 80'd0);

    // Drops: three with id 12, one at the boundary id 10.
    node_ready_i = 10'h3FF;
    link_v_i     = 1'b1;
    link_data_i  = in_pkt(4'd12);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("drop_yumi_%0d", k), W'(link_yumi_o), 80'd1);
      check($sformatf("drop_node_v_%0d", k), W'(node_v_o), 80'd0);
      step();
    end
    link_v_i = 1'b0;
    #1;
    check("drop_count_3", W'(drop_count_o), 80'd3);
    link_v_i    = 1'b1;
    link_data_i = in_pkt(4'd10);
    step();
    link_v_i = 1'b0;
    check("drop_count_4", W'(drop_count_o), 80'd4);

    // Saturation: push well past 0xFFFF drops.
    link_v_i    = 1'b1;
    link_data_i = in_pkt(4'd15);
    repeat (65531) @(posedge clk);
    #1;
    check("drop_reach_ffff", W'(drop_count_o), 80'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("drop_saturated", W'(drop_count_o), 80'hFFFF);
    link_v_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
